bb_arbiter: RTL and testbench
=============================

BB_ARBITER -- requirements
Module: bb_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 2, number of bus masters (2..4).
REQ-002 Port clk  input  1  bus clock, all state on rising edge.
REQ-003 Port rstn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-004 Port breq  input  NUM_MASTERS  per-master bus request, held high for the whole transaction, including while split.
REQ-005 Port bgrant  output  NUM_MASTERS  one-hot-or-zero grant to masters.
REQ-006 Port msel  output  $clog2(NUM_MASTERS)  index of the master whose signals the bus mux routes.
REQ-007 Port bus_busy  output  1  high while a master holds the grant.
REQ-008 Port sl_split  input  1  single-cycle pulse from the addressed slave: split the current transaction.
REQ-009 Port sl_split_done  input  1  single-cycle pulse from a slave: split data is ready, resume.
REQ-010 Port split  output  NUM_MASTERS  per-master split indication, high from split acceptance until resume.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner); all outputs registered.
REQ-012 In IDLE, the eligible set SHALL be breq with the bit of any split-pending master masked off.
REQ-013 In IDLE, a resume-pending master whose breq is high SHALL be granted ahead of all others.
REQ-014 Otherwise, the block SHALL grant the first eligible master at or after rr_ptr, in ascending index order with wrap-around.
REQ-015 On grant, the block SHALL go to BUSY and set bgrant[k]=1, msel=k and bus_busy=1 on the next rising edge (1-cycle latency from breq).
REQ-016 On grant to master k, the block SHALL set rr_ptr to (k+1) mod NUM_MASTERS; a resume grant SHALL also clear resume-pending.
REQ-017 In BUSY, when breq[owner]=0, the block SHALL clear bgrant and bus_busy next cycle and return to IDLE.
REQ-018 Arbitration SHALL NOT happen in the cycle BUSY exits, so there is at least one idle cycle between owners.
REQ-019 In BUSY, sl_split=1 with no split pending SHALL, next cycle, record the owner as split_owner, set split[owner]=1, clear bgrant and go to IDLE.
REQ-020 sl_split SHALL be ignored in IDLE or when a split is already pending (at most one outstanding split).
REQ-021 sl_split_done=1 with a split pending SHALL, next cycle, clear split[split_owner] and set resume-pending.
REQ-022 sl_split_done with no split pending SHALL be ignored.
REQ-023 If sl_split_done and sl_split occur in the same cycle, done SHALL take effect and the split SHALL be ignored.
REQ-024 If the split master drops breq while split or resume-pending, the block SHALL clear split and resume-pending for it next cycle.
REQ-025 msel SHALL hold its last value while IDLE.
REQ-026 bgrant SHALL never have more than one bit set.
REQ-027 split and bgrant SHALL never both be set for the same master.
REQ-028 An implementation SHALL be 120-400 lines of RTL.

Reset
REQ-029 While rstn=0, the block SHALL drive state=IDLE, bgrant=0, msel=0, bus_busy=0, split=0, rr_ptr=0, split pending=0, resume-pending=0.
REQ-030 Reset SHALL take effect immediately on rstn falling, regardless of clk.
REQ-031 Reset mid-transaction or mid-split SHALL drop all grants and split indications; after reset, arbitration SHALL restart from master 0.

Verification
REQ-032 Single request: breq=01 from IDLE -> bgrant=01, msel=0, bus_busy=1 one cycle later; breq=00 -> bgrant=00 next cycle.
REQ-033 Round-robin: breq=11 held, each owner drops breq after 4 cycles then re-raises -> grants alternate 01,10,01 with one idle cycle between owners.
REQ-034 Split: master 0 owns, sl_split pulse -> split=01, bgrant=00, then bgrant=10 if breq[1]=1; sl_split_done -> split=00, master 0 granted next after master 1 releases, ahead of rr_ptr.
REQ-035 Illegal split events: second sl_split while split pending -> no change; sl_split_done with none pending -> no change; simultaneous done+split -> split cleared, no new split recorded.
REQ-036 Reset mid-split: split=01, bgrant=10, rstn low asynchronously -> all outputs 0 immediately; after release, breq=11 -> bgrant=01.
REQ-037 Bench SHALL continuously check REQ-026 and REQ-027 as assertions.

Source files
------------

// File: rtl/bb_arbiter.sv
// bb_arbiter: round-robin bus arbiter with split-transaction support.
// Request/grant semantics: a master raises breq[k] and holds it for the whole
// transaction, including while split. bgrant[k] rises one clock after the
// arbiter picks it. The transaction ends in the cycle where the owner samples
// low breq, and bgrant drops on the next edge. A slave may pulse sl_split to
// park the owner: split[k] marks it until sl_split_done, after which it is
// re-granted ahead of the round-robin order.
module bb_arbiter #(
    parameter int NUM_MASTERS = 2
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [NUM_MASTERS-1:0]         breq,
    output logic [NUM_MASTERS-1:0]         bgrant,
    output logic [$clog2(NUM_MASTERS)-1:0] msel,
    output logic                           bus_busy,
    input  logic                           sl_split,
    input  logic                           sl_split_done,
    output logic [NUM_MASTERS-1:0]         split,
    output logic                           dbg_state
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_MASTERS-1:0] bgrant_q, bgrant_d;
    logic [NUM_MASTERS-1:0] split_q, split_d;
    logic [NUM_MASTERS-1:0] resume_q, resume_d;
    logic [IDX_W-1:0]       msel_q, msel_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic                   busy_q, busy_d;

    logic [NUM_MASTERS-1:0] eligible;
    logic [NUM_MASTERS-1:0] resume_req;
    logic                   rr_found;
    logic [IDX_W-1:0]       rr_idx;
    logic                   res_found;
    logic [IDX_W-1:0]       res_idx;
    int unsigned            cand;
    logic                   split_accept;

    // Candidate selection: resume winner and first eligible master from rr_ptr.
    always_comb begin
        eligible   = breq & ~split_q;
        resume_req = resume_q & breq;
        res_found  = |resume_req;
        res_idx    = '0;
        rr_found   = 1'b0;
        rr_idx     = '0;
        cand       = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (resume_req[i]) begin
                res_idx = IDX_W'(i);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            cand = (32'(rr_ptr_q) + 32'(i)) % NUM_MASTERS;
            if (!rr_found && eligible[cand]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'(cand);
            end
        end
    end

    // Next-state logic for ownership, split and resume tracking.
    always_comb begin
        state_d  = state_q;
        bgrant_d = bgrant_q;
        msel_d   = msel_q;
        busy_d   = busy_q;
        rr_ptr_d = rr_ptr_q;
        // A master that lets go of breq forfeits its split/resume status.
        split_d  = split_q & breq;
        resume_d = resume_q & breq;
        // Split and resume are never pending together, so done can simply
        // move the split bit over to resume.
        if (sl_split_done && (|split_q)) begin
            split_d  = '0;
            resume_d = split_q & breq;
        end
        // Only one split outstanding (including its resume phase); a
        // simultaneous done wins over a new split; a release wins over split.
        split_accept = (state_q == ST_BUSY) && breq[msel_q] && sl_split &&
                       !sl_split_done && !(|split_q) && !(|resume_q);

        case (state_q)
            ST_IDLE: begin
                if (res_found) begin
                    state_d           = ST_BUSY;
                    bgrant_d          = '0;
                    bgrant_d[res_idx] = 1'b1;
                    msel_d            = res_idx;
                    busy_d            = 1'b1;
                    rr_ptr_d          = IDX_W'((32'(res_idx) + 32'd1) % NUM_MASTERS);
                    resume_d          = '0;
                end else if (rr_found) begin
                    state_d          = ST_BUSY;
                    bgrant_d         = '0;
                    bgrant_d[rr_idx] = 1'b1;
                    msel_d           = rr_idx;
                    busy_d           = 1'b1;
                    rr_ptr_d         = IDX_W'((32'(rr_idx) + 32'd1) % NUM_MASTERS);
                end
            end
            ST_BUSY: begin
                // No arbitration here: the next owner is picked from IDLE,
                // which guarantees one idle cycle between owners.
                if (!breq[msel_q] || split_accept) begin
                    state_d  = ST_IDLE;
                    bgrant_d = '0;
                    busy_d   = 1'b0;
                end
                if (split_accept) begin
                    split_d = bgrant_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                bgrant_d = '0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            bgrant_q <= '0;
            split_q  <= '0;
            resume_q <= '0;
            msel_q   <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bgrant_q <= bgrant_d;
            split_q  <= split_d;
            resume_q <= resume_d;
            msel_q   <= msel_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

    assign bgrant    = bgrant_q;
    assign msel      = msel_q;
    assign bus_busy  = busy_q;
    assign split     = split_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bb_arbiter.sv
// tb_bb_arbiter: directed vector table, reset-mid-split sequence and a
// randomized run against an ownership-level reference model (3 masters).
module tb_bb_arbiter;

    localparam int NM = 3;
    localparam int IW = 2;
    localparam int NV = 34;
    localparam int N_RAND = 3000;

    logic          clk;
    logic          rstn;
    logic [NM-1:0] breq;
    logic [NM-1:0] bgrant;
    logic [IW-1:0] msel;
    logic          bus_busy;
    logic          sl_split;
    logic          sl_split_done;
    logic [NM-1:0] split;
    logic          dbg_state;

    int n_vec = 0;
    int n_err = 0;

    bb_arbiter #(.NUM_MASTERS(NM)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .breq          (breq),
        .bgrant        (bgrant),
        .msel          (msel),
        .bus_busy      (bus_busy),
        .sl_split      (sl_split),
        .sl_split_done (sl_split_done),
        .split         (split),
        .dbg_state     (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Grant exclusivity and split/grant exclusivity, checked every cycle.
    a_onehot: assert property (@(posedge clk) disable iff (!rstn) $onehot0(bgrant))
        else begin
            n_err++;
            $display("FAIL onehot_bgrant: bgrant=%b", bgrant);
        end
    a_split_excl: assert property (@(posedge clk) disable iff (!rstn) ((split & bgrant) == '0))
        else begin
            n_err++;
            $display("FAIL split_grant_excl: split=%b bgrant=%b", split, bgrant);
        end

    typedef struct packed {
        logic [NM-1:0] rq;
        logic          sp;
        logic          dn;
        logic [NM-1:0] eg;
        logic [IW-1:0] em;
        logic          eb;
        logic [NM-1:0] es;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic [NM-1:0] rq, input logic sp, input logic dn,
                                input logic [NM-1:0] eg, input logic [IW-1:0] em,
                                input logic eb, input logic [NM-1:0] es);
        vec_t v;
        v.rq = rq; v.sp = sp; v.dn = dn;
        v.eg = eg; v.em = em; v.eb = eb; v.es = es;
        return v;
    endfunction

    // Reference model: who owns the bus, who is parked, who is waiting to resume.
    int m_owner, m_split, m_resume, m_ptr, m_sel;

    task automatic model_reset();
        m_owner  = -1;
        m_split  = -1;
        m_resume = -1;
        m_ptr    = 0;
        m_sel    = 0;
    endtask

    task automatic model_step(input logic [NM-1:0] rq, input logic sp, input logic dn);
        int n_owner, n_split, n_resume;
        n_owner  = m_owner;
        n_split  = m_split;
        n_resume = m_resume;
        if (m_split >= 0) begin
            if (!rq[m_split]) n_split = -1;
            else if (dn) begin
                n_split  = -1;
                n_resume = m_split;
            end
        end
        if (m_resume >= 0 && !rq[m_resume]) n_resume = -1;
        if (m_owner >= 0) begin
            if (!rq[m_owner]) n_owner = -1;
            else if (sp && !dn && m_split < 0 && m_resume < 0) begin
                n_split = m_owner;
                n_owner = -1;
            end
        end else if (m_resume >= 0 && rq[m_resume]) begin
            n_owner  = m_resume;
            n_resume = -1;
            m_sel    = m_resume;
            m_ptr    = (m_resume + 1) % NM;
        end else begin
            for (int off = 0; off < NM; off++) begin
                int k;
                k = (m_ptr + off) % NM;
                if (n_owner < 0 && rq[k] && k != m_split) begin
                    n_owner = k;
                end
            end
            if (n_owner >= 0) begin
                m_sel = n_owner;
                m_ptr = (n_owner + 1) % NM;
            end
        end
        m_owner  = n_owner;
        m_split  = n_split;
        m_resume = n_resume;
    endtask

    // Driver: inputs change on the falling edge, outputs are sampled 1ns after the rising edge.
    task automatic apply(input logic [NM-1:0] rq, input logic sp, input logic dn);
        @(negedge clk);
        breq          = rq;
        sl_split      = sp;
        sl_split_done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [NM-1:0] eg, input logic [IW-1:0] em,
                         input logic eb, input logic [NM-1:0] es);
        n_vec++;
        if ({bgrant, msel, bus_busy, split, dbg_state} !== {eg, em, eb, es, eb}) begin
            n_err++;
            $display("FAIL %s: got bgrant=%b msel=%0d busy=%b split=%b state=%b, want bgrant=%b msel=%0d busy=%b split=%b state=%b",
                     name, bgrant, msel, bus_busy, split, dbg_state, eg, em, eb, es, eb);
        end
    endtask

    initial begin
        logic [NM-1:0] rq_cur;
        logic          sp, dn;
        logic [NM-1:0] exp_g, exp_s;

        // Directed table: each row is one clock from the previous row's state.
        vecs[0]  = mk(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[1]  = mk(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[2]  = mk(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000);
        vecs[3]  = mk(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000);
        vecs[4]  = mk(3'b011, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[5]  = mk(3'b011, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[6]  = mk(3'b001, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 3'b000);
        vecs[7]  = mk(3'b011, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[8]  = mk(3'b011, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[9]  = mk(3'b010, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000);
        vecs[10] = mk(3'b011, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[11] = mk(3'b001, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 3'b000);
        vecs[12] = mk(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[13] = mk(3'b011, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'b001);
        vecs[14] = mk(3'b011, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 3'b001);
        vecs[15] = mk(3'b011, 1'b1, 1'b0, 3'b010, 2'd1, 1'b1, 3'b001);
        vecs[16] = mk(3'b111, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[17] = mk(3'b101, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 3'b000);
        vecs[18] = mk(3'b111, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[19] = mk(3'b110, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000);
        vecs[20] = mk(3'b110, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[21] = mk(3'b110, 1'b0, 1'b1, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[22] = mk(3'b110, 1'b1, 1'b1, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[23] = mk(3'b110, 1'b1, 1'b0, 3'b000, 2'd1, 1'b0, 3'b010);
        vecs[24] = mk(3'b111, 1'b0, 1'b0, 3'b100, 2'd2, 1'b1, 3'b010);
        vecs[25] = mk(3'b111, 1'b1, 1'b1, 3'b100, 2'd2, 1'b1, 3'b000);
        vecs[26] = mk(3'b011, 1'b0, 1'b0, 3'b000, 2'd2, 1'b0, 3'b000);
        vecs[27] = mk(3'b011, 1'b0, 1'b0, 3'b010, 2'd1, 1'b1, 3'b000);
        vecs[28] = mk(3'b001, 1'b0, 1'b0, 3'b000, 2'd1, 1'b0, 3'b000);
        vecs[29] = mk(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[30] = mk(3'b001, 1'b1, 1'b0, 3'b000, 2'd0, 1'b0, 3'b001);
        vecs[31] = mk(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000);
        vecs[32] = mk(3'b001, 1'b0, 1'b0, 3'b001, 2'd0, 1'b1, 3'b000);
        vecs[33] = mk(3'b000, 1'b0, 1'b0, 3'b000, 2'd0, 1'b0, 3'b000);

        // Reset
        rstn          = 1'b0;
        breq          = '0;
        sl_split      = 1'b0;
        sl_split_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 3'b000, 2'd0, 1'b0, 3'b000);
        @(negedge clk);
        rstn = 1'b1;

        // Directed vectors
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].rq, vecs[i].sp, vecs[i].dn);
            check($sformatf("vec%0d", i), vecs[i].eg, vecs[i].em, vecs[i].eb, vecs[i].es);
        end

        // Reset in the middle of a split: master 0 parked, master 1 on the bus.
        apply(3'b001, 1'b0, 1'b0);
        check("rs_grant0", 3'b001, 2'd0, 1'b1, 3'b000);
        apply(3'b011, 1'b1, 1'b0);
        check("rs_split0", 3'b000, 2'd0, 1'b0, 3'b001);
        apply(3'b011, 1'b0, 1'b0);
        check("rs_grant1", 3'b010, 2'd1, 1'b1, 3'b001);
        @(negedge clk);
        sl_split = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check("rs_async_clear", 3'b000, 2'd0, 1'b0, 3'b000);
        @(negedge clk);
        rstn = 1'b1;
        breq = 3'b011;
        @(posedge clk);
        #1;
        check("rs_restart_m0", 3'b001, 2'd0, 1'b1, 3'b000);

        // Randomized run against the reference model.
        @(negedge clk);
        rstn          = 1'b0;
        breq          = '0;
        sl_split      = 1'b0;
        sl_split_done = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
        rq_cur = '0;
        for (int c = 0; c < N_RAND; c++) begin
            for (int k = 0; k < NM; k++) begin
                if ($urandom_range(0, 7) == 0) rq_cur[k] = ~rq_cur[k];
            end
            sp = ($urandom_range(0, 5) == 0);
            dn = ($urandom_range(0, 7) == 0);
            apply(rq_cur, sp, dn);
            model_step(rq_cur, sp, dn);
            exp_g = (m_owner >= 0) ? (NM'(1) << m_owner) : '0;
            exp_s = (m_split >= 0) ? (NM'(1) << m_split) : '0;
            check($sformatf("rand%0d", c), exp_g, IW'(m_sel), (m_owner >= 0), exp_s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
